cook_timer: RTL and testbench

- Downstream countdown stage of the oven simulator. Consumes the four BCD timer digits produced by the digit-entry stage, in mm:ss format.
- Counts the loaded time down once per second and drives heater enable and display digits.
- Asserts a completion alarm for a fixed number of seconds at 00:00, then returns to idle.

---
 rtl/cook_timer.sv | 160 ++++++++++++++++
 tb/tb_cook_timer.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cook_timer.sv
// Oven countdown stage: loads mm:ss BCD digits, counts down once per second, then raises a timed alarm.
// Optional door interlock is enabled by defining DOOR_INTERLOCK_EN.
module cook_timer #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int ALARM_SECS    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       cancel,
`ifdef DOOR_INTERLOCK_EN
    input  logic       door_open,
`endif
    input  logic [3:0] din0,
    input  logic [3:0] din1,
    input  logic [3:0] din2,
    input  logic [3:0] din3,
    output logic [3:0] dout0,
    output logic [3:0] dout1,
    output logic [3:0] dout2,
    output logic [3:0] dout3,
    output logic       heat_on,
    output logic       done,
    output logic       busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_ALARM = 2'd3;

    localparam int PW = $clog2(TICKS_PER_SEC + 1);
    localparam int AW = $clog2(ALARM_SECS + 1);

    logic [1:0]    r_state;
    logic [PW-1:0] r_presc;
    logic [AW-1:0] r_alarm;
    logic [3:0]    r_d0, r_d1, r_d2, r_d3;

    logic          w_door;
    logic          w_tick;
    logic [3:0]    w_l0, w_l1, w_l2, w_l3;
    logic          w_load_nz;
    logic [3:0]    w_n0, w_n1, w_n2, w_n3;
    logic          w_n_zero;
    logic          w_start_ok;
    logic          w_hold;

`ifdef DOOR_INTERLOCK_EN
    assign w_door = door_open;
`else
    assign w_door = 1'b0;
`endif

    assign w_tick = ((r_state == S_RUN) || (r_state == S_ALARM))
                    && (r_presc == PW'(TICKS_PER_SEC - 1));

    function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] mx);
        return (d > mx) ? mx : d;
    endfunction

    assign w_l0      = clamp(din0, 4'd9);
    assign w_l1      = clamp(din1, 4'd5);
    assign w_l2      = clamp(din2, 4'd9);
    assign w_l3      = clamp(din3, 4'd9);
    assign w_load_nz = |{w_l3, w_l2, w_l1, w_l0};

    // mm:ss borrow chain; a zero value is left untouched
    always_comb begin
        w_n0 = r_d0;
        w_n1 = r_d1;
        w_n2 = r_d2;
        w_n3 = r_d3;
        if (r_d0 != 4'd0) begin
            w_n0 = r_d0 - 4'd1;
        end else if (r_d1 != 4'd0) begin
            w_n0 = 4'd9;
            w_n1 = r_d1 - 4'd1;
        end else if (r_d2 != 4'd0) begin
            w_n0 = 4'd9;
            w_n1 = 4'd5;
            w_n2 = r_d2 - 4'd1;
        end else if (r_d3 != 4'd0) begin
            w_n0 = 4'd9;
            w_n1 = 4'd5;
            w_n2 = 4'd9;
            w_n3 = r_d3 - 4'd1;
        end
    end

    assign w_n_zero   = ({w_n3, w_n2, w_n1, w_n0} == 16'd0);
    assign w_start_ok = start && !w_door;
    assign w_hold     = pause || w_door;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_alarm <= '0;
            {r_d3, r_d2, r_d1, r_d0} <= 16'd0;
        end else if (cancel) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_alarm <= '0;
            {r_d3, r_d2, r_d1, r_d0} <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_presc <= '0;
                    {r_d3, r_d2, r_d1, r_d0} <= {din3, din2, din1, din0};
                    if (w_start_ok && w_load_nz) begin
                        r_state <= S_RUN;
                        {r_d3, r_d2, r_d1, r_d0} <= {w_l3, w_l2, w_l1, w_l0};
                    end
                end
                S_RUN: begin
                    r_presc <= w_tick ? '0 : r_presc + 1'b1;
                    if (w_tick) begin
                        {r_d3, r_d2, r_d1, r_d0} <= {w_n3, w_n2, w_n1, w_n0};
                    end
                    if (w_tick && w_n_zero) begin
                        r_state <= S_ALARM;
                        r_presc <= '0;
                        r_alarm <= '0;
                    end else if (w_hold) begin
                        r_state <= S_PAUSE;
                        r_presc <= '0;
                    end
                end
                S_PAUSE: begin
                    r_presc <= '0;
                    if (w_start_ok) begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_presc <= w_tick ? '0 : r_presc + 1'b1;
                    if (w_tick) begin
                        if (r_alarm == AW'(ALARM_SECS - 1)) begin
                            r_state <= S_IDLE;
                            r_alarm <= '0;
                        end else begin
                            r_alarm <= r_alarm + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign dout0   = r_d0;
    assign dout1   = r_d1;
    assign dout2   = r_d2;
    assign dout3   = r_d3;
    assign heat_on = (r_state == S_RUN) && !w_door;
    assign done    = (r_state == S_ALARM);
    assign busy    = (r_state == S_RUN) || (r_state == S_PAUSE);

endmodule

// File: tb/tb_cook_timer.sv
// Bench for cook_timer: directed scenarios plus random pulses against a seconds-based reference model.
// Door interlock scenarios are included when DOOR_INTERLOCK_EN is defined.
module tb_cook_timer;

    localparam int TPS = 4;
    localparam int AS  = 3;
    localparam int MI  = 0;
    localparam int MR  = 1;
    localparam int MP  = 2;
    localparam int MA  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       cancel = 1'b0;
    logic       door_open = 1'b0;
    logic [3:0] din0 = 4'd0, din1 = 4'd0, din2 = 4'd0, din3 = 4'd0;
    logic [3:0] dout0, dout1, dout2, dout3;
    logic       heat_on, done, busy;

    int errors = 0;
    int checks = 0;

    int          m_mode = MI;
    int          m_secs = 0;
    int          m_cnt  = 0;
    int          m_al   = 0;
    logic [15:0] m_disp = 16'd0;

    cook_timer #(.TICKS_PER_SEC(TPS), .ALARM_SECS(AS)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .pause(pause),
        .cancel(cancel),
`ifdef DOOR_INTERLOCK_EN
        .door_open(door_open),
`endif
        .din0(din0),
        .din1(din1),
        .din2(din2),
        .din3(din3),
        .dout0(dout0),
        .dout1(dout1),
        .dout2(dout2),
        .dout3(dout3),
        .heat_on(heat_on),
        .done(done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int mn(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [15:0] todig(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic int san_secs();
        int mm, ss;
        mm = mn(int'(din3), 9) * 10 + mn(int'(din2), 9);
        ss = mn(int'(din1), 5) * 10 + mn(int'(din0), 9);
        return mm * 60 + ss;
    endfunction

    function automatic logic [18:0] exp_vec();
        logic h, d, b;
        h = (m_mode == MR) && !door_open;
        d = (m_mode == MA);
        b = (m_mode == MR) || (m_mode == MP);
        return {m_disp, h, d, b};
    endfunction

    function automatic logic [18:0] act_vec();
        return {dout3, dout2, dout1, dout0, heat_on, done, busy};
    endfunction

    function automatic logic [15:0] dout_w();
        return {dout3, dout2, dout1, dout0};
    endfunction

    // Remaining time is kept as plain seconds; one step per clock edge
    task automatic model_step();
        bit tk;
        int s;
        tk = ((m_mode == MR) || (m_mode == MA)) && (m_cnt == TPS - 1);
        if (rst) begin
            m_mode = MI; m_cnt = 0; m_al = 0; m_secs = 0; m_disp = 16'd0;
        end else if (cancel) begin
            m_mode = MI; m_cnt = 0; m_al = 0; m_secs = 0; m_disp = 16'd0;
        end else begin
            case (m_mode)
                MI: begin
                    m_disp = {din3, din2, din1, din0};
                    s = san_secs();
                    if (start && !door_open && s > 0) begin
                        m_mode = MR; m_secs = s; m_cnt = 0; m_disp = todig(s);
                    end
                end
                MR: begin
                    m_cnt = tk ? 0 : m_cnt + 1;
                    if (tk) begin
                        m_secs = m_secs - 1;
                        m_disp = todig(m_secs);
                    end
                    if (tk && m_secs == 0) begin
                        m_mode = MA; m_cnt = 0; m_al = 0;
                    end else if (pause || door_open) begin
                        m_mode = MP; m_cnt = 0;
                    end
                end
                MP: begin
                    if (start && !door_open) begin
                        m_mode = MR; m_cnt = 0;
                    end
                end
                default: begin
                    m_cnt = tk ? 0 : m_cnt + 1;
                    if (tk) begin
                        m_al = m_al + 1;
                        if (m_al == AS) begin
                            m_mode = MI; m_al = 0; m_cnt = 0;
                        end
                    end
                end
            endcase
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_din(input logic [3:0] d3, input logic [3:0] d2,
                           input logic [3:0] d1, input logic [3:0] d0);
        din3 = d3; din2 = d2; din1 = d1; din0 = d0;
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic pulse_cancel();
        cancel = 1'b1; cyc(); cancel = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        checks++;
        if (act_vec() !== 19'd0) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", act_vec(), 19'd0);
        end
        rst = 1'b0;
        set_din(4'd0, 4'd0, 4'd3, 4'd0);
        cyc();
        pulse_start();
        repeat (6) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (act_vec() !== 19'd0 || exp_vec() !== 19'd0) begin
            errors++;
            $display("FAIL reset_midcount got=%h exp=%h", act_vec(), 19'd0);
        end
    endtask

    task automatic test_countdown();
        set_din(4'd0, 4'd0, 4'd1, 4'd0);
        cyc();
        pulse_start();
        checks++;
        if (heat_on !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL cd_heat_on got=%b exp=1", heat_on);
        end
        repeat (4) cyc();
        checks++;
        if (dout_w() !== 16'h0009) begin
            errors++;
            $display("FAIL cd_first_tick got=%h exp=0009", dout_w());
        end
        repeat (35) cyc();
        checks++;
        if (done !== 1'b0 || dout_w() !== 16'h0001) begin
            errors++;
            $display("FAIL cd_before_zero got=%h/%b exp=0001/0", dout_w(), done);
        end
        cyc();
        checks++;
        if (done !== 1'b1 || heat_on !== 1'b0 || dout_w() !== 16'h0000) begin
            errors++;
            $display("FAIL cd_alarm got=%h/%b exp=0000/1", dout_w(), done);
        end
        repeat (11) cyc();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL cd_alarm_hold got=%b exp=1", done);
        end
        cyc();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cd_alarm_end got=%b exp=0", done);
        end
        cyc();
        checks++;
        if (act_vec() !== exp_vec() || dout_w() !== 16'h0010) begin
            errors++;
            $display("FAIL cd_idle_follow got=%h exp=%h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_borrow();
        set_din(4'd0, 4'd1, 4'd0, 4'd0);
        cyc();
        pulse_start();
        repeat (4) cyc();
        checks++;
        if (dout_w() !== 16'h0059) begin
            errors++;
            $display("FAIL borrow_min got=%h exp=0059", dout_w());
        end
        pulse_cancel();
        set_din(4'd1, 4'd0, 4'd0, 4'd0);
        cyc();
        pulse_start();
        repeat (4) cyc();
        checks++;
        if (dout_w() !== 16'h0959) begin
            errors++;
            $display("FAIL borrow_tens got=%h exp=0959", dout_w());
        end
        pulse_cancel();
    endtask

    task automatic test_sanitize();
        set_din(4'd0, 4'd0, 4'd7, 4'd12);
        cyc();
        pulse_start();
        checks++;
        if (dout_w() !== 16'h0059 || act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL sanitize got=%h exp=0059", dout_w());
        end
        pulse_cancel();
    endtask

    task automatic test_pause();
        bit bad;
        set_din(4'd0, 4'd0, 4'd0, 4'd5);
        cyc();
        pulse_start();
        repeat (8) cyc();
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        checks++;
        if (dout_w() !== 16'h0003 || heat_on !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pause_enter got=%h/%b exp=0003/0", dout_w(), heat_on);
        end
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (dout_w() !== 16'h0003 || heat_on !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL pause_hold got=%h/%b exp=0003/0", dout_w(), heat_on);
        end
        pulse_start();
        repeat (11) cyc();
        checks++;
        if (dout_w() !== 16'h0001 || done !== 1'b0) begin
            errors++;
            $display("FAIL resume_pre got=%h exp=0001", dout_w());
        end
        cyc();
        checks++;
        if (dout_w() !== 16'h0000 || done !== 1'b1) begin
            errors++;
            $display("FAIL resume_zero got=%h/%b exp=0000/1", dout_w(), done);
        end
        pulse_cancel();
    endtask

    task automatic test_cancel_tick();
        set_din(4'd0, 4'd0, 4'd0, 4'd5);
        cyc();
        pulse_start();
        repeat (4) cyc();
        checks++;
        if (dout_w() !== 16'h0004) begin
            errors++;
            $display("FAIL ct_run got=%h exp=0004", dout_w());
        end
        repeat (3) cyc();
        pulse_cancel();
        checks++;
        if (dout_w() !== 16'h0000 || busy !== 1'b0 || heat_on !== 1'b0) begin
            errors++;
            $display("FAIL ct_cancel got=%h/%b exp=0000/0", dout_w(), busy);
        end
        cyc();
        checks++;
        if (dout_w() !== 16'h0005) begin
            errors++;
            $display("FAIL ct_follow got=%h exp=0005", dout_w());
        end
        set_din(4'd0, 4'd0, 4'd0, 4'd0);
        cyc();
        pulse_start();
        repeat (5) cyc();
        checks++;
        if (heat_on !== 1'b0 || busy !== 1'b0 || dout_w() !== 16'h0000) begin
            errors++;
            $display("FAIL zero_start got=%b/%b exp=0/0", heat_on, busy);
        end
    endtask

`ifdef DOOR_INTERLOCK_EN
    task automatic test_door();
        set_din(4'd0, 4'd0, 4'd0, 4'd9);
        cyc();
        pulse_start();
        repeat (2) cyc();
        door_open = 1'b1;
        #1;
        checks++;
        if (heat_on !== 1'b0) begin
            errors++;
            $display("FAIL door_gate got=%b exp=0", heat_on);
        end
        cyc();
        checks++;
        if (busy !== 1'b1 || heat_on !== 1'b0 || act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL door_pause got=%h exp=%h", act_vec(), exp_vec());
        end
        pulse_start();
        door_open = 1'b0;
        repeat (6) cyc();
        checks++;
        if (heat_on !== 1'b0 || dout_w() !== 16'h0009) begin
            errors++;
            $display("FAIL door_start_ign got=%h/%b exp=0009/0", dout_w(), heat_on);
        end
        pulse_start();
        checks++;
        if (heat_on !== 1'b1) begin
            errors++;
            $display("FAIL door_resume got=%b exp=1", heat_on);
        end
        pulse_cancel();
    endtask
`endif

    task automatic test_random();
        int bad;
        int first;
        bad = 0;
        first = -1;
        for (int i = 0; i < 1200; i++) begin
            start  = ($urandom % 6) == 0;
            pause  = ($urandom % 20) == 0;
            cancel = ($urandom % 60) == 0;
            rst    = ($urandom % 400) == 0;
`ifdef DOOR_INTERLOCK_EN
            if (($urandom % 25) == 0) door_open = ~door_open;
`endif
            if (($urandom % 12) == 0) begin
                set_din(4'd0, 4'($urandom % 2), 4'($urandom % 16), 4'($urandom % 16));
            end
            cyc();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                bad++;
                if (bad <= 5) begin
                    $display("FAIL random_cyc%0d got=%h exp=%h", i, act_vec(), exp_vec());
                end
            end
        end
        start = 1'b0; pause = 1'b0; cancel = 1'b0; rst = 1'b0; door_open = 1'b0;
        if (first != -1) $display("random first=%0d", first);
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_borrow();
        test_sanitize();
        test_pause();
        test_cancel_tick();
`ifdef DOOR_INTERLOCK_EN
        test_door();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
